// File: rtl/input_conditioner.sv
// input_conditioner: two-flop synchronizer plus debounce filter for the raw
// X1/X2 sources. Each channel produces a clean level and registered rise/fall
// strobes. chg is the OR of all four strobes.
module input_conditioner #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic raw_x1,
  input  logic raw_x2,
  output logic X1,
  output logic X2,
  output logic x1_rise,
  output logic x1_fall,
  output logic x2_rise,
  output logic x2_fall,
  output logic chg
);

  localparam logic [7:0] LAST = 8'(DB_CYCLES - 1);

  // Channel 0 is X1 and channel 1 is X2.
  logic [1:0] raw;
  logic [1:0] s1;
  logic [1:0] s2;
  logic [1:0] level;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] toggle;
  logic [7:0] cnt [2];

  assign raw = {raw_x2, raw_x1};

  // A channel flips when it has stayed mismatched for the last counted cycle while enabled.
  always_comb begin
    toggle = '0;
    for (int unsigned ch = 0; ch < 2; ch++) begin
      toggle[ch] = (s2[ch] != level[ch]) && en && (cnt[ch] == LAST);
    end
  end

  // Two-flop synchronizers. They keep running even when en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Debounce counters and output levels. Strobes are registered alongside the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
      rise  <= '0;
      fall  <= '0;
      chg   <= 1'b0;
      for (int unsigned ch = 0; ch < 2; ch++) begin
        cnt[ch] <= '0;
      end
    end else begin
      for (int unsigned ch = 0; ch < 2; ch++) begin
        if (s2[ch] == level[ch]) begin
          cnt[ch] <= '0;
        end else if (en) begin
          if (toggle[ch]) begin
            cnt[ch]   <= '0;
            level[ch] <= s2[ch];
          end else begin
            cnt[ch] <= cnt[ch] + 8'd1;
          end
        end
      end
      rise <= toggle & s2;
      fall <= toggle & ~s2;
      chg  <= |toggle;
    end
  end

  assign X1      = level[0];
  assign X2      = level[1];
  assign x1_rise = rise[0];
  assign x1_fall = fall[0];
  assign x2_rise = rise[1];
  assign x2_fall = fall[1];

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner. Two instances (DB_CYCLES=4 and 1)
// share the same stimulus. The driver pushes the expected outputs of both
// instances for each edge, and the monitor pops and compares them after the edge.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic raw_x1 = 1'b0;
  logic raw_x2 = 1'b0;

  logic X1, X2, x1_rise, x1_fall, x2_rise, x2_fall, chg;
  logic d_X1, d_X2, d_x1_rise, d_x1_fall, d_x2_rise, d_x2_fall, d_chg;

  int checks = 0;
  int errors = 0;

  logic [13:0] sb [$];

  // Reference state: synchronizer history, level and run length of enabled mismatches.
  logic sync1 [2][2];
  logic sync2 [2][2];
  logic lvl   [2][2];
  int   run   [2][2];

  input_conditioner #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .en(en), .raw_x1(raw_x1), .raw_x2(raw_x2),
    .X1(X1), .X2(X2), .x1_rise(x1_rise), .x1_fall(x1_fall),
    .x2_rise(x2_rise), .x2_fall(x2_fall), .chg(chg)
  );

  input_conditioner #(.DB_CYCLES(1)) dut_db1 (
    .clk(clk), .rst(rst), .en(en), .raw_x1(raw_x1), .raw_x2(raw_x2),
    .X1(d_X1), .X2(d_X2), .x1_rise(d_x1_rise), .x1_fall(d_x1_fall),
    .x2_rise(d_x2_rise), .x2_fall(d_x2_fall), .chg(d_chg)
  );

  always #5 clk = ~clk;

  function automatic int db_of(input int inst);
    return (inst == 0) ? 4 : 1;
  endfunction

  // Output layout per instance: {chg, x2_fall, x2_rise, x1_fall, x1_rise, X2, X1}.
  task automatic model_edge(input logic r, input logic e, input logic [1:0] rw,
                            output logic [13:0] ev);
    ev = '0;
    for (int i = 0; i < 2; i++) begin
      logic [6:0] o;
      o = '0;
      for (int c = 0; c < 2; c++) begin
        if (r) begin
          sync1[i][c] = 1'b0;
          sync2[i][c] = 1'b0;
          lvl[i][c]   = 1'b0;
          run[i][c]   = 0;
        end else begin
          if (sync2[i][c] == lvl[i][c]) begin
            run[i][c] = 0;
          end else if (e) begin
            run[i][c]++;
            if (run[i][c] == db_of(i)) begin
              lvl[i][c] = sync2[i][c];
              run[i][c] = 0;
              o[2 + 2 * c + (lvl[i][c] ? 0 : 1)] = 1'b1;
            end
          end
          sync2[i][c] = sync1[i][c];
          sync1[i][c] = rw[c];
        end
      end
      o[0] = lvl[i][0];
      o[1] = lvl[i][1];
      o[6] = |o[5:2];
      ev[7 * i +: 7] = o;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic a, input logic b);
    logic [13:0] ev;
    @(negedge clk);
    rst = r;
    en = e;
    raw_x1 = a;
    raw_x2 = b;
    model_edge(r, e, {b, a}, ev);
    sb.push_back(ev);
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, got, exp);
    end
  endtask

  // Monitor: after each edge, compare the DUT outputs against the next expected entry.
  initial begin
    logic [13:0] got;
    logic [13:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        got = {d_chg, d_x2_fall, d_x2_rise, d_x1_fall, d_x1_rise, d_X2, d_X1,
               chg, x2_fall, x2_rise, x1_fall, x1_rise, X2, X1};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL scoreboard t=%0t got %b expected %b", $time, got, exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // Reset is held with both raw inputs high. Both levels rise on the sixth edge after release.
    step(1, 1, 1, 1);
    chk("rst_x1", X1, 1'b0);
    chk("rst_rise", x1_rise, 1'b0);
    step(1, 1, 1, 1);
    chk("rst_x2", X2, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      step(0, 1, 1, 1);
      if (n == 5) begin
        chk("rst_rel_x1_early", X1, 1'b0);
        chk("rst_rel_x2_early", X2, 1'b0);
      end
      if (n == 6) begin
        chk("rst_rel_x1", X1, 1'b1);
        chk("rst_rel_x2", X2, 1'b1);
        chk("rst_rel_rise", x1_rise, 1'b1);
        chk("rst_rel_chg", chg, 1'b1);
      end
    end

    // Clean step on X1 only.
    repeat (8) step(0, 1, 0, 0);
    for (int n = 1; n <= 7; n++) begin
      step(0, 1, 1, 0);
      if (n == 5) chk("clean_x1_early", X1, 1'b0);
      if (n == 6) begin
        chk("clean_x1", X1, 1'b1);
        chk("clean_rise", x1_rise, 1'b1);
        chk("clean_chg", chg, 1'b1);
        chk("clean_x2", X2, 1'b0);
        chk("clean_x2_rise", x2_rise, 1'b0);
      end
      if (n == 7) chk("clean_rise_clear", x1_rise, 1'b0);
    end

    // A three-cycle glitch on X2 is rejected, and a stable high is then accepted.
    for (int n = 1; n <= 9; n++) begin
      step(0, 1, 1, (n <= 3) ? 1'b1 : 1'b0);
      chk("glitch_x2", X2, 1'b0);
      chk("glitch_rise", x2_rise, 1'b0);
    end
    for (int n = 1; n <= 7; n++) begin
      step(0, 1, 1, 1);
      if (n == 5) chk("stable_x2_early", X2, 1'b0);
      if (n == 6) begin
        chk("stable_x2", X2, 1'b1);
        chk("stable_rise", x2_rise, 1'b1);
      end
    end

    // Two disabled cycles in the middle of an X1 fall delay it by two edges.
    for (int n = 1; n <= 9; n++) begin
      step(0, (n == 5 || n == 6) ? 1'b0 : 1'b1, 0, 1);
      if (n == 6 || n == 7) chk("gate_x1_hold", X1, 1'b1);
      if (n == 7) chk("gate_no_fall", x1_fall, 1'b0);
      if (n == 8) begin
        chk("gate_x1", X1, 1'b0);
        chk("gate_fall", x1_fall, 1'b1);
      end
      if (n == 9) chk("gate_fall_clear", x1_fall, 1'b0);
    end

    // Both inputs rise together.
    repeat (8) step(0, 1, 0, 0);
    for (int n = 1; n <= 7; n++) begin
      step(0, 1, 1, 1);
      if (n == 6) begin
        chk("sim_x1", X1, 1'b1);
        chk("sim_x2", X2, 1'b1);
        chk("sim_r1", x1_rise, 1'b1);
        chk("sim_r2", x2_rise, 1'b1);
        chk("sim_chg", chg, 1'b1);
      end
      if (n == 7) chk("sim_chg_clear", chg, 1'b0);
    end

    // A reset pulse while the count is at 2 cancels the change, which then needs the full latency again.
    repeat (8) step(0, 1, 0, 0);
    for (int n = 1; n <= 12; n++) begin
      step((n == 5) ? 1'b1 : 1'b0, 1, 1, 0);
      if (n == 10) chk("midrst_x1_early", X1, 1'b0);
      if (n == 11) chk("midrst_x1", X1, 1'b1);
    end

    // Randomized traffic: inputs toggle sparsely, en is mostly high, and reset is rare.
    for (int n = 0; n < 600; n++) begin
      logic a;
      logic b;
      a = raw_x1;
      b = raw_x2;
      if ($urandom_range(0, 5) == 0) a = ~a;
      if ($urandom_range(0, 5) == 0) b = ~b;
      step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, a, b);
    end

    for (int n = 0; n < 4 && sb.size() > 0; n++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage for the two-input sequential detector: takes the asynchronous raw `X1`/`X2` sources, synchronizes them into the `clk` domain and debounces them, then drives clean, glitch-free `X1`/`X2` levels straight into the detector's inputs. It also produces single-cycle rise/fall strobes per channel and an any-change strobe for the downstream monitor logic. Both channels are identical and independent.

## Interface
Parameters:
- `DB_CYCLES`, default 4: number of consecutive enabled cycles a synchronized input must differ from its output before the output follows. Legal range 1..255.

Ports:
- `clk` input, 1 bit: single clock, rising-edge active.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `en` input, 1 bit: debounce count enable. When low, counters and outputs hold; the synchronizers keep running.
- `raw_x1` input, 1 bit: asynchronous raw source for channel 1.
- `raw_x2` input, 1 bit: asynchronous raw source for channel 2.
- `X1` output, 1 bit: debounced level, channel 1. Feeds the detector's `X1`.
- `X2` output, 1 bit: debounced level, channel 2. Feeds the detector's `X2`.
- `x1_rise` output, 1 bit: one-cycle pulse when `X1` goes 0->1.
- `x1_fall` output, 1 bit: one-cycle pulse when `X1` goes 1->0.
- `x2_rise` output, 1 bit: one-cycle pulse when `X2` goes 0->1.
- `x2_fall` output, 1 bit: one-cycle pulse when `X2` goes 1->0.
- `chg` output, 1 bit: OR of the four edge pulses, registered in the same cycle as they are.

## Operation
- Synchronizer, per channel: `s1 <= raw`, `s2 <= s1`, two flops. Only `s2` is used downstream.
- Debounce counter, per channel, 8 bits (`cnt`), applied every rising edge in priority order:
  - `rst` high: `s1`, `s2`, `cnt`, `X`, all pulses and `chg` go to 0.
  - `s2 == X`: `cnt <= 0`. This applies even when `en` is low; a glitch shorter than the threshold is discarded.
  - `s2 != X` and `en` low: `cnt` holds and `X` holds.
  - `s2 != X`, `en` high, `cnt == DB_CYCLES-1`: `X <= s2`, `cnt <= 0`, and the matching rise/fall pulse is set.
  - `s2 != X`, `en` high, otherwise: `cnt <= cnt + 1`.
- Pulses are registered. They are high for exactly the one cycle following the edge on which `X` changes, coincident with the new `X` value, and clear on the next edge unless another toggle occurs.
- The two channels never interact. Simultaneous qualifying changes flip `X1` and `X2` on the same edge. `chg` is high for one cycle in that case.
- Counter arithmetic never wraps: `cnt` is capped by the toggle at `DB_CYCLES-1`.
- Reset values: `X1=0`, `X2=0`, all pulses 0, `chg=0`.

## Timing
- Latency: a raw level first captured by `s1` at edge k, held stable, with `en` high throughout, appears on `X` at edge k+1+DB_CYCLES. With the default this is edge k+5. Pulses appear on the same edge.
- A mismatch that ends before the toggle edge resets `cnt`. The next change restarts the full count.
- Each low cycle of `en` during a mismatch delays the toggle by one edge.
- `rst` asserted mid-count: every register is cleared on that edge. After release, an input that is already high needs the full k+1+DB_CYCLES from its new capture.
- `DB_CYCLES=1`: `X` follows `s2` one edge after `s2` changes, with no filtering.
- Minimum separation between two pulses on one channel: DB_CYCLES cycles.

## Test plan
- Reset: assert `rst` 2 cycles with `raw_x1=raw_x2=1` -> `X1=X2=0`, all pulses 0 during reset. `X1`/`X2` rise at edge 6 after release (DB=4, `en=1`).
- Clean step: `raw_x1` 0->1 captured at edge 10, held -> `X1=1` from edge 15, `x1_rise=1` only in the cycle after edge 15, `chg=1` with it. `X2` and `x2_*` stay 0.
- Glitch rejection: `raw_x2` high for 3 cycles then low (DB=4) -> `X2` stays 0, no `x2_rise`. A following 4-cycle-stable high toggles `X2` at the full latency.
- Enable gating: during a `raw_x1` 1->0 mismatch, drop `en` for 2 cycles after 2 counts -> `X1` falls 2 edges later than the ungated case, with a single `x1_fall`.
- Simultaneous: `raw_x1` and `raw_x2` both rise in the same cycle -> `X1` and `X2` rise on the same edge, `x1_rise=x2_rise=1`, `chg` high exactly 1 cycle.
- Reset mid-count: pulse `rst` when `cnt=2` -> no toggle. After release, the change takes the full k+5 again.
